decode_dispatch_queue: RTL and testbench
========================================

// Module: decode_dispatch_queue
// PURPOSE
//  Next-generation decode/dispatch stage: an IQ_DEPTH-entry instruction queue between the InstFetcher and decode, with a valid/ready fetch handshake, predictor-directed branch redirect and ROB flush.
//  Decodes the queue head (RV32I) and dispatches one packed uop per cycle to the ReorderBuffer, plus ReservationStation or LoadStoreBuffer.
// PARAMETERS
//  IQ_DEPTH        4   instruction queue entries (power of 2, >=2)
//  ROB_WIDTH_BIT   4   ROB tag width (RW)
//  UOP_W           3*RW+188  packed uop width (derived, do not override)
// PORTS
//  clk_in          in   1     clock
//  rst_n_in        in   1     reset, asynchronous, active-low
//  rdy_in          in   1     low = freeze all state and outputs
//  flush_in        in   1     ROB mispredict flush
//  fetch_valid     in   1     fetcher offers {fetch_addr,fetch_inst}
//  fetch_ready     out  1     queue not full (count<IQ_DEPTH), combinational
//  fetch_addr      in   32    instruction address
//  fetch_inst      in   32    instruction word
//  pred_addr       out  32    head address, to branch predictor
//  pred_taken      in   1     predictor says taken for pred_addr (same cycle)
//  reg_id1/reg_id2 out  5     head rs1/rs2 index to RegFile (one line: two ports)
//  reg_val1        in   32    rs1 value
//  reg_val2        in   32    rs2 value
//  reg_dep1        in   RW+1  [RW]=busy, [RW-1:0]=producing ROB tag for rs1
//  reg_dep2        in   RW+1  same for rs2
//  rob_full        in   1     ROB cannot accept
//  rob_free_id     in   RW    tag the next ROB entry will get
//  rs_full         in   1     RS cannot accept
//  lsb_full        in   1     LSB cannot accept
//  rob_valid       out  1     uop valid to ROB (1-cycle pulse)
//  rs_valid        out  1     uop valid to RS
//  lsb_valid       out  1     uop valid to LSB
//  uop             out  UOP_W packed uop, shared by ROB/RS/LSB
//  redirect_valid  out  1     fetch redirect pulse; fetcher drops its pending work
//  redirect_addr   out  32    new fetch PC
// BEHAVIOUR
//  uop {MSB..LSB}: pred_taken1, alt_addr32, inst_addr32, value32, rob_ready1, rd5, rob_type2, unit_type5, imm12, r2_32, r1_32, dep2(RW+1), dep1(RW+1), rob_id(RW)
//  Queue: circular, wr/rd ptrs wrap mod IQ_DEPTH, count 0..IQ_DEPTH.
//  - Push on fetch_valid&&fetch_ready.
//  - Pop on dispatch.
//  - Push and pop may coincide.
//  - No pop-bypass of fetch_ready at full.
//  Dispatch requires all of: count>0, rdy_in, !flush_in, !rob_full; !rs_full for BR/OP/OP-IMM; !lsb_full for LOAD/STORE; !reg_dep1[RW] for JALR.
//  Latency: head dispatched at edge N; valids/uop/redirect are registered and visible after N for exactly one cycle. rob_valid always set on dispatch.
//  Operand tags and rob_id:
//  - depX = use_rsX ? reg_depX : 0. rs1 used by JALR/BR/LD/ST/OP/OP-IMM; rs2 by BR/ST/OP.
//  - rob_id=rob_free_id.
//  Operand values, all 32-bit wrap:
//  - r1=reg_val1.
//  - r2 = OP-IMM ? (func3 001/101 ? zext shamt : sext immI) : reg_val2.
//  - imm = LOAD ? immI : immS.
//  - All immediates sign-extend from inst[31].
//  unit_type:
//  - RS: {is_BR, inst[30]&&(OP || OP-IMM&&func3==101), func3}.
//  - LSB: {0, is_STORE, func3}.
//  rob_type: ST=1 store, BR=2 branch, EX=3 unknown opcode, else RG=0.
//  rob_ready=1 for LUI/AUIPC/JAL/JALR/EX.
//  rob value:
//  - LUI immU<<12; AUIPC addr+(immU<<12); JAL/JALR addr+4; else 0.
//  - EX/ST/BR: rd forced 0.
//  Redirect: JAL -> addr+sext(immJ); JALR -> (reg_val1+sext(immI))&~1; BR with pred_taken -> addr+sext(immB).
//  - A redirect also empties the queue at the same edge; a coincident push is dropped.
//  - BR: alt_addr = pred_taken ? addr+4 : target; non-BR alt_addr=0.
//  flush_in: next edge count=ptrs=0, all valids and redirect_valid=0; beats push and dispatch.
//  Not dispatching (rdy_in high): valids and redirect_valid 0; uop and redirect_addr hold.
//  rdy_in low: everything holds, no push/pop.
//  Reset (async, immediate): all valids, redirect_valid, ptrs, count, uop, redirect_addr = 0; fetch_ready=1 after release.
// TESTING
//  1 Push ADDI x1,x0,5 (0x00500093) @0x0 -> next cycle rob_valid=rs_valid=1, lsb_valid=0, r2=5, unit_type=0, rd=1, rob_id=rob_free_id.
//  2 rob_full=1, push 4 insts -> fetch_ready=0; drop rob_full -> 1 dispatch/cycle in order; 5th push accepted the cycle after first pop.
//  3 JAL x1,+8 (0x008000ef) @0x100, 2 entries behind -> redirect 0x108, value=0x104, rob_ready=1, count=0 next cycle.
//  4 BEQ -4 @0x200: pred_taken=0 -> no redirect, alt=0x1FC; pred_taken=1 -> redirect 0x1FC, alt=0x204.
//  5 JALR x0,0(x5), reg_dep1 busy 3 cycles -> no dispatch; free, val=0x1001 -> redirect 0x1000.
//  6 flush_in with push + dispatchable head -> no valids, count 0. Assert rst_n_in mid-stream -> outputs 0 without clock edge.

Source files
------------

// File: rtl/decode_dispatch_queue_if.sv
// Fetch-side valid/ready handshake between the InstFetcher and
// the decode/dispatch instruction queue.
interface decode_dispatch_queue_if;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_inst;

  modport master (
    output fetch_valid,
    output fetch_addr,
    output fetch_inst,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  fetch_addr,
    input  fetch_inst,
    output fetch_ready
  );
endinterface

// File: rtl/decode_dispatch_queue.sv
// RV32I instruction queue + head decoder: dispatches one packed uop
// per cycle to ROB and RS/LSB, redirects fetch on jumps/taken branches.
module decode_dispatch_queue #(
  parameter int IQ_DEPTH      = 4,
  parameter int ROB_WIDTH_BIT = 4,
  localparam int RW    = ROB_WIDTH_BIT,
  localparam int UOP_W = 3*RW+188
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  decode_dispatch_queue_if.slave fetch,
  output logic [31:0]      pred_addr,
  input  logic             pred_taken,
  output logic [4:0]       reg_id1,
  output logic [4:0]       reg_id2,
  input  logic [31:0]      reg_val1,
  input  logic [31:0]      reg_val2,
  input  logic [RW:0]      reg_dep1,
  input  logic [RW:0]      reg_dep2,
  input  logic             rob_full,
  input  logic [RW-1:0]    rob_free_id,
  input  logic             rs_full,
  input  logic             lsb_full,
  output logic             rob_valid,
  output logic             rs_valid,
  output logic             lsb_valid,
  output logic [UOP_W-1:0] uop,
  output logic             redirect_valid,
  output logic [31:0]      redirect_addr
);

  localparam int PW = $clog2(IQ_DEPTH);

  logic [31:0] q_addr [IQ_DEPTH];
  logic [31:0] q_inst [IQ_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;

  logic [31:0] h_addr, h_inst;
  logic [6:0]  opc;
  logic [2:0]  f3;

  assign h_addr = q_addr[rd_ptr];
  assign h_inst = q_inst[rd_ptr];
  assign opc    = h_inst[6:0];
  assign f3     = h_inst[14:12];

  assign pred_addr = h_addr;
  assign reg_id1   = h_inst[19:15];
  assign reg_id2   = h_inst[24:20];

  assign fetch.fetch_ready = (count != (PW+1)'(IQ_DEPTH));

  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_load, is_store, is_opimm, is_op;

  assign is_lui   = (opc == 7'b0110111);
  assign is_auipc = (opc == 7'b0010111);
  assign is_jal   = (opc == 7'b1101111);
  assign is_jalr  = (opc == 7'b1100111);
  assign is_br    = (opc == 7'b1100011);
  assign is_load  = (opc == 7'b0000011);
  assign is_store = (opc == 7'b0100011);
  assign is_opimm = (opc == 7'b0010011);
  assign is_op    = (opc == 7'b0110011);

  logic [31:0] imm_i, imm_b, imm_j, imm_u;

  assign imm_i = {{20{h_inst[31]}}, h_inst[31:20]};
  assign imm_b = {{19{h_inst[31]}}, h_inst[31], h_inst[7],
                  h_inst[30:25], h_inst[11:8], 1'b0};
  assign imm_j = {{11{h_inst[31]}}, h_inst[31], h_inst[19:12],
                  h_inst[20], h_inst[30:21], 1'b0};
  assign imm_u = {h_inst[31:12], 12'b0};

  logic        use_rs1, use_rs2, to_rs, to_lsb;
  logic        rob_ready, redir;
  logic [1:0]  rob_type;
  logic [4:0]  rd;
  logic [31:0] value, tgt, alt;

  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    to_rs     = 1'b0;
    to_lsb    = 1'b0;
    rob_ready = 1'b0;
    redir     = 1'b0;
    rob_type  = 2'd0;
    rd        = h_inst[11:7];
    value     = 32'd0;
    tgt       = 32'd0;
    alt       = 32'd0;
    unique case (1'b1)
      is_lui: begin
        rob_ready = 1'b1;
        value     = imm_u;
      end
      is_auipc: begin
        rob_ready = 1'b1;
        value     = h_addr + imm_u;
      end
      is_jal: begin
        rob_ready = 1'b1;
        value     = h_addr + 32'd4;
        redir     = 1'b1;
        tgt       = h_addr + imm_j;
      end
      is_jalr: begin
        use_rs1   = 1'b1;
        rob_ready = 1'b1;
        value     = h_addr + 32'd4;
        redir     = 1'b1;
        tgt       = (reg_val1 + imm_i) & ~32'd1;
      end
      is_br: begin
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        to_rs    = 1'b1;
        rob_type = 2'd2;
        rd       = 5'd0;
        redir    = pred_taken;
        tgt      = h_addr + imm_b;
        alt      = pred_taken ? h_addr + 32'd4
                              : h_addr + imm_b;
      end
      is_load: begin
        use_rs1 = 1'b1;
        to_lsb  = 1'b1;
      end
      is_store: begin
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        to_lsb   = 1'b1;
        rob_type = 2'd1;
        rd       = 5'd0;
      end
      is_opimm: begin
        use_rs1 = 1'b1;
        to_rs   = 1'b1;
      end
      is_op: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        to_rs   = 1'b1;
      end
      default: begin
        rob_type  = 2'd3;
        rob_ready = 1'b1;
        rd        = 5'd0;
      end
    endcase
  end

  logic        shamt;
  logic [31:0] r2;
  logic [11:0] imm12;
  logic [4:0]  unit_type;
  logic [RW:0] dep1, dep2;

  assign shamt = (f3 == 3'b001) || (f3 == 3'b101);
  assign r2 = !is_opimm ? reg_val2 :
              shamt     ? {27'd0, h_inst[24:20]} : imm_i;
  assign imm12 = is_load ? h_inst[31:20]
                         : {h_inst[31:25], h_inst[11:7]};
  assign dep1 = use_rs1 ? reg_dep1 : '0;
  assign dep2 = use_rs2 ? reg_dep2 : '0;

  always_comb begin
    unit_type = 5'd0;
    if (to_rs)
      unit_type = {is_br,
                   h_inst[30] & (is_op | (is_opimm & (f3 == 3'b101))),
                   f3};
    else if (to_lsb)
      unit_type = {1'b0, is_store, f3};
  end

  logic [UOP_W-1:0] uop_n;

  assign uop_n = {pred_taken, alt, h_addr, value, rob_ready, rd,
                  rob_type, unit_type, imm12, r2, reg_val1,
                  dep2, dep1, rob_free_id};

  logic dispatch, fire, push;

  // JALR needs a settled rs1 to form its target before dispatch
  assign dispatch = (count != '0) & rdy_in & ~flush_in & ~rob_full
                  & ~(to_rs & rs_full) & ~(to_lsb & lsb_full)
                  & ~(is_jalr & reg_dep1[RW]);
  assign fire = dispatch & redir;
  assign push = fetch.fetch_valid & fetch.fetch_ready & rdy_in
              & ~flush_in & ~fire;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        q_addr[i] <= 32'd0;
        q_inst[i] <= 32'd0;
      end
    end else if (push) begin
      q_addr[wr_ptr] <= fetch.fetch_addr;
      q_inst[wr_ptr] <= fetch.fetch_inst;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      rob_valid      <= 1'b0;
      rs_valid       <= 1'b0;
      lsb_valid      <= 1'b0;
      redirect_valid <= 1'b0;
      uop            <= '0;
      redirect_addr  <= 32'd0;
    end else if (rdy_in) begin
      rob_valid      <= dispatch;
      rs_valid       <= dispatch & to_rs;
      lsb_valid      <= dispatch & to_lsb;
      redirect_valid <= fire;
      if (dispatch)
        uop <= uop_n;
      if (fire)
        redirect_addr <= tgt;
      if (flush_in || fire) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (dispatch)
          rd_ptr <= rd_ptr + 1'b1;
        unique case ({push, dispatch})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decode_dispatch_queue.sv
// Randomized + directed bench for decode_dispatch_queue against a
// queue-based behavioural model of the decode/dispatch rules.
module tb_decode_dispatch_queue;
  localparam int D  = 4;
  localparam int RW = 4;
  localparam int UW = 3*RW+188;

  localparam int O_ID  = 0;
  localparam int O_D1  = RW;
  localparam int O_D2  = 2*RW+1;
  localparam int O_R1  = 3*RW+2;
  localparam int O_R2  = O_R1+32;
  localparam int O_IMM = O_R2+32;
  localparam int O_UT  = O_IMM+12;
  localparam int O_RT  = O_UT+5;
  localparam int O_RD  = O_RT+2;
  localparam int O_RR  = O_RD+5;
  localparam int O_VAL = O_RR+1;
  localparam int O_IA  = O_VAL+32;
  localparam int O_ALT = O_IA+32;
  localparam int O_PT  = O_ALT+32;

  logic clk = 1'b0;
  logic rst_n, rdy, flush, pt, robf, rsf, lsbf;
  logic [31:0] v1, v2, pred_addr, redirect_addr;
  logic [RW:0] d1, d2;
  logic [RW-1:0] fid;
  logic [4:0] reg_id1, reg_id2;
  logic rob_valid, rs_valid, lsb_valid, redirect_valid;
  logic [UW-1:0] uop;

  decode_dispatch_queue_if fif();

  decode_dispatch_queue #(.IQ_DEPTH(D), .ROB_WIDTH_BIT(RW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush),
    .fetch(fif.slave), .pred_addr(pred_addr), .pred_taken(pt),
    .reg_id1(reg_id1), .reg_id2(reg_id2),
    .reg_val1(v1), .reg_val2(v2), .reg_dep1(d1), .reg_dep2(d2),
    .rob_full(robf), .rob_free_id(fid), .rs_full(rsf),
    .lsb_full(lsbf), .rob_valid(rob_valid), .rs_valid(rs_valid),
    .lsb_valid(lsb_valid), .uop(uop),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] i;
  } ent_t;

  ent_t mq[$];
  logic e_rob, e_rs, e_lsb, e_red;
  logic [UW-1:0] e_uop;
  logic [31:0] e_raddr;
  int total = 0;
  int bad = 0;

  task automatic chk(input string n, input logic [255:0] a,
                     input logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  function automatic logic [31:0] sx(input logic [31:0] v, input int b);
    logic [31:0] m;
    m = 32'd1 << b;
    v = v & (m - 32'd1);
    return (v ^ (m >> 1)) - (m >> 1);
  endfunction

  // 0 LUI 1 AUIPC 2 JAL 3 JALR 4 BR 5 LD 6 ST 7 OPIMM 8 OP 9 other
  function automatic int kind(input logic [31:0] i);
    case (i[6:0])
      7'h37: return 0;
      7'h17: return 1;
      7'h6F: return 2;
      7'h67: return 3;
      7'h63: return 4;
      7'h03: return 5;
      7'h23: return 6;
      7'h13: return 7;
      7'h33: return 8;
      default: return 9;
    endcase
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [6:0] ops [10];
    logic [31:0] r;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
            7'h03, 7'h23, 7'h13, 7'h33, 7'h0B};
    r = $urandom;
    return {r[31:7], ops[$urandom_range(0, 9)]};
  endfunction

  task automatic model_reset();
    mq.delete();
    {e_rob, e_rs, e_lsb, e_red} = 4'b0;
    e_uop = '0;
    e_raddr = 32'd0;
  endtask

  task automatic model_step();
    ent_t h;
    int k;
    logic [31:0] iI, iS, iB, iJ, f3;
    bit push, rsk, lsk, go, red;
    logic [UW-1:0] u;
    if (!rdy) return;
    if (flush) begin
      mq.delete();
      {e_rob, e_rs, e_lsb, e_red} = 4'b0;
      return;
    end
    push = fif.fetch_valid && mq.size() < D;
    {e_rob, e_rs, e_lsb, e_red} = 4'b0;
    if (mq.size() > 0) begin
      h = mq[0];
      k = kind(h.i);
      f3 = (h.i >> 12) & 7;
      iI = sx(h.i >> 20, 12);
      iS = sx(((h.i >> 25) << 5) | ((h.i >> 7) & 31), 12);
      iB = sx(((h.i >> 31) << 12) | (((h.i >> 7) & 1) << 11)
            | (((h.i >> 25) & 63) << 5) | (((h.i >> 8) & 15) << 1), 13);
      iJ = sx(((h.i >> 31) << 20) | (((h.i >> 12) & 255) << 12)
            | (((h.i >> 20) & 1) << 11) | (((h.i >> 21) & 1023) << 1), 21);
      rsk = k inside {4, 7, 8};
      lsk = k inside {5, 6};
      go = !robf && !(rsk && rsf) && !(lsk && lsbf)
         && !(k == 3 && d1[RW]);
      if (go) begin
        u = '0;
        u[O_ID +: RW] = fid;
        u[O_D1 +: RW+1] = (k inside {3,4,5,6,7,8}) ? d1 : '0;
        u[O_D2 +: RW+1] = (k inside {4,6,8}) ? d2 : '0;
        u[O_R1 +: 32] = v1;
        if (k == 7)
          u[O_R2 +: 32] = (f3 == 1 || f3 == 5) ? (h.i >> 20) & 31 : iI;
        else
          u[O_R2 +: 32] = v2;
        u[O_IMM +: 12] = (k == 5) ? iI[11:0] : iS[11:0];
        if (rsk)
          u[O_UT +: 5] = 5'(((k == 4) ? 16 : 0) + f3 +
            ((h.i[30] && (k == 8 || (k == 7 && f3 == 5))) ? 8 : 0));
        else if (lsk)
          u[O_UT +: 5] = 5'(((k == 6) ? 8 : 0) + f3);
        u[O_RT +: 2] = (k == 6) ? 2'd1 : (k == 4) ? 2'd2 :
                       (k == 9) ? 2'd3 : 2'd0;
        u[O_RD +: 5] = (k inside {4, 6, 9}) ? 5'd0 : h.i[11:7];
        u[O_RR] = k inside {0, 1, 2, 3, 9};
        case (k)
          0: u[O_VAL +: 32] = h.i & 32'hFFFFF000;
          1: u[O_VAL +: 32] = h.a + (h.i & 32'hFFFFF000);
          2, 3: u[O_VAL +: 32] = h.a + 4;
          default: u[O_VAL +: 32] = 32'd0;
        endcase
        u[O_IA +: 32] = h.a;
        if (k == 4) u[O_ALT +: 32] = pt ? h.a + 4 : h.a + iB;
        u[O_PT] = pt;
        e_uop = u;
        e_rob = 1'b1;
        e_rs = rsk;
        e_lsb = lsk;
        red = (k == 2) || (k == 3) || (k == 4 && pt);
        mq.pop_front();
        if (red) begin
          e_red = 1'b1;
          e_raddr = (k == 2) ? h.a + iJ :
                    (k == 3) ? (v1 + iI) & ~32'd1 : h.a + iB;
          mq.delete();
          push = 0;
        end
      end
    end
    if (push) mq.push_back('{fif.fetch_addr, fif.fetch_inst});
  endtask

  // one clock: combinational checks, edge, registered checks
  task automatic cyc();
    #1;
    chk("fetch_ready", fif.fetch_ready, mq.size() < D);
    if (mq.size() > 0) begin
      chk("pred_addr", pred_addr, mq[0].a);
      chk("reg_id1", reg_id1, mq[0].i[19:15]);
      chk("reg_id2", reg_id2, mq[0].i[24:20]);
    end
    model_step();
    @(posedge clk);
    #1;
    chk("rob_valid", rob_valid, e_rob);
    chk("rs_valid", rs_valid, e_rs);
    chk("lsb_valid", lsb_valid, e_lsb);
    chk("redirect_valid", redirect_valid, e_red);
    chk("uop", uop, e_uop);
    chk("redirect_addr", redirect_addr, e_raddr);
    @(negedge clk);
  endtask

  task automatic idle();
    rdy = 1; flush = 0; pt = 0; robf = 0; rsf = 0; lsbf = 0;
    v1 = 0; v2 = 0; d1 = 0; d2 = 0; fid = 4'd3;
    fif.fetch_valid = 0; fif.fetch_addr = 0; fif.fetch_inst = 0;
  endtask

  task automatic push1(input logic [31:0] a, input logic [31:0] i);
    fif.fetch_valid = 1; fif.fetch_addr = a; fif.fetch_inst = i;
    cyc();
    fif.fetch_valid = 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    model_reset();
    #1;
    chk("rst_rob_valid", rob_valid, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_uop", uop, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_fetch_ready", fif.fetch_ready, 1);

    // ADDI x1,x0,5
    push1(32'h0, 32'h00500093);
    cyc();
    chk("t1_rob", rob_valid, 1);
    chk("t1_rs", rs_valid, 1);
    chk("t1_lsb", lsb_valid, 0);
    chk("t1_r2", uop[O_R2 +: 32], 5);
    chk("t1_unit", uop[O_UT +: 5], 0);
    chk("t1_rd", uop[O_RD +: 5], 1);
    chk("t1_robid", uop[O_ID +: RW], 3);

    // fill under rob_full, then drain in order with a late 5th push
    robf = 1;
    for (int n = 1; n <= 4; n++) push1(32'(4*n), 32'h00000013);
    chk("t2_full", fif.fetch_ready, 0);
    robf = 0;
    fif.fetch_valid = 1; fif.fetch_addr = 32'd20;
    fif.fetch_inst = 32'h00000013;
    for (int n = 1; n <= 5; n++) begin
      if (n == 3) fif.fetch_valid = 0;
      cyc();
      chk("t2_order", uop[O_IA +: 32], 32'(4*n));
    end

    // JAL x1,+8 with two entries behind it
    robf = 1;
    push1(32'h100, 32'h008000ef);
    push1(32'h104, 32'h00000013);
    push1(32'h108, 32'h00000013);
    robf = 0;
    cyc();
    chk("t3_redir", redirect_valid, 1);
    chk("t3_raddr", redirect_addr, 32'h108);
    chk("t3_value", uop[O_VAL +: 32], 32'h104);
    chk("t3_ready", uop[O_RR], 1);
    cyc();
    chk("t3_empty", rob_valid, 0);

    // BEQ -4, not taken then taken
    push1(32'h200, 32'hfe000ee3);
    cyc();
    chk("t4_nt_redir", redirect_valid, 0);
    chk("t4_nt_alt", uop[O_ALT +: 32], 32'h1FC);
    push1(32'h200, 32'hfe000ee3);
    pt = 1;
    cyc();
    pt = 0;
    chk("t4_t_redir", redirect_valid, 1);
    chk("t4_t_raddr", redirect_addr, 32'h1FC);
    chk("t4_t_alt", uop[O_ALT +: 32], 32'h204);

    // JALR x0,0(x5) waits on busy rs1
    push1(32'h300, 32'h00028067);
    d1 = {1'b1, 4'd2};
    repeat (3) begin
      cyc();
      chk("t5_stall", rob_valid, 0);
    end
    d1 = 0; v1 = 32'h1001;
    cyc();
    chk("t5_redir", redirect_valid, 1);
    chk("t5_raddr", redirect_addr, 32'h1000);
    v1 = 0;

    // flush beats push and dispatch
    push1(32'h400, 32'h00000013);
    flush = 1;
    push1(32'h404, 32'h00000013);
    flush = 0;
    chk("t6_flush_nv", rob_valid, 0);
    cyc();
    chk("t6_flush_empty", rob_valid, 0);

    // asynchronous reset mid-stream
    push1(32'h500, 32'h00000013);
    push1(32'h504, 32'h00000013);
    chk("t6_pre_rst", rob_valid, 1);
    rst_n = 0;
    #1;
    chk("t6_arst_rob", rob_valid, 0);
    chk("t6_arst_uop", uop, 0);
    chk("t6_arst_raddr", redirect_addr, 0);
    chk("t6_arst_ready", fif.fetch_ready, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cyc();
    chk("t6_post_rst", rob_valid, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 39) == 0);
      robf  = ($urandom_range(0, 4) == 0);
      rsf   = ($urandom_range(0, 4) == 0);
      lsbf  = ($urandom_range(0, 4) == 0);
      pt    = $urandom_range(0, 1) != 0;
      v1 = $urandom; v2 = $urandom;
      d1 = (RW+1)'($urandom); d2 = (RW+1)'($urandom);
      fid = RW'($urandom);
      fif.fetch_valid = ($urandom_range(0, 9) < 6);
      fif.fetch_addr  = $urandom & 32'hFFFFFFFC;
      fif.fetch_inst  = gen_inst();
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
